operand_mux: RTL and testbench
==============================

// Module: operand_mux
// PURPOSE
//   Operand source selector for the ALU second-operand path of the complex CPU.
//   Chooses between the 12-bit immediate ("rop") field of the instruction and a
//   32-bit general-purpose register value.
//   The immediate is extended to the datapath width.
//   Sits between decode/register-file read and the ALU input.
// PARAMETERS
//   ROP_W     12   immediate operand width
//   DATA_W    32   datapath / GPR width (DATA_W > ROP_W)
//   SIGN_EXT  0    0: zero-extend rop; 1: sign-extend rop (rop[ROP_W-1] replicated)
// PORTS
//   clk       in   1        system clock, rising edge
//   rst       in   1        synchronous reset, active-high
//   sel       in   1        source select: 0 = rop, 1 = GPR
//   rop       in   ROP_W    immediate operand from instruction
//   GPR       in   DATA_W   register-file read value
//   data_out  out  DATA_W   selected, extended operand
//   src_q     out  1        registered copy of sel (last-cycle source), debug/status
// BEHAVIOUR
//   - One clock (clk); reset is synchronous and active-high (rst).
//   - Default build: data_out is purely combinational, zero latency:
//       sel=0 -> data_out = ext(rop); sel=1 -> data_out = GPR.
//   - ext(rop), SIGN_EXT=0: {(DATA_W-ROP_W){1'b0}, rop}; all upper bits 0.
//   - ext(rop), SIGN_EXT=1: {(DATA_W-ROP_W){rop[ROP_W-1]}, rop}.
//   - sel toggling: data_out follows the new source in the same delta; no glitch
//     filtering, no memory of the previous source in the data path.
//   - sel X/Z: data_out driven to all-X in simulation (no silent default).
//   - src_q: on each rising clk, src_q <= sel; rst=1 at edge -> src_q <= 0.
//     Reset value 0.
//   - rst has no effect on combinational data_out.
//   - Boundaries:
//     - rop = all-ones (4095) with SIGN_EXT=0 -> 0x0000_0FFF.
//     - GPR = 0xFFFF_FFFF passes unmodified.
//     - rop = 0 -> 0.
// CONFIGURATION
//   OPERAND_MUX_REG_EN defined:
//     - data_out is registered: data_out <= mux result on rising clk.
//     - Latency is 1 cycle.
//     - rst=1 at edge -> data_out <= 0; reset value 0.
//   OPERAND_MUX_REG_EN undefined:
//     - Combinational data_out as above.
//     - src_q remains registered in both builds.
// STRUCTURE
//   Package operand_mux_pkg:
//     - localparams ROP_W_DEF=12, DATA_W_DEF=32.
//     - typedef enum logic {SRC_ROP=1'b0, SRC_GPR=1'b1} src_e.
//     - function ext_imm() for zero/sign extension.
//   Sub-module operand_ext (rop -> DATA_W extender, SIGN_EXT parameter).
//     Instantiated once; the mux and optional output register are in operand_mux.
//   Elaboration-time assertion DATA_W > ROP_W.
// TESTING
//   1. sel=0, rop=4095, GPR=0xFFFF_FFFF, wait 10ns
//      -> data_out == 0x0000_0FFF (== rop zero-extended).
//   2. sel=1, same inputs, wait 10ns -> data_out == 0xFFFF_FFFF.
//   3. sel back to 0, wait 10ns -> data_out == 0x0000_0FFF; verifies no stale GPR value.
//   4. SIGN_EXT=1, sel=0, rop=0x800 -> data_out == 0xFFFF_F800;
//      rop=0x7FF -> 0x0000_07FF.
//   5. rst=1 for 2 clk, sel=1 -> src_q == 0 during reset; first edge after release -> src_q == 1.
//   6. OPERAND_MUX_REG_EN build:
//      - sel=1, GPR=0x1234_5678 -> data_out unchanged until next edge, then 0x1234_5678.
//      - rst -> data_out == 0 after the edge.

Source files
------------

// File: rtl/operand_mux_pkg.sv
// Shared types and the immediate-extension helper for the ALU second-operand selector.
package operand_mux_pkg;

    localparam int unsigned ROP_W_DEF  = 12;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned EXT_MAX_W  = 64;

    typedef enum logic {
        SRC_ROP = 1'b0,
        SRC_GPR = 1'b1
    } src_e;

    // Extends the low rop_w bits of raw to EXT_MAX_W; callers truncate to their datapath width.
    function automatic logic [EXT_MAX_W-1:0] ext_imm(
        input logic [EXT_MAX_W-1:0] raw,
        input int unsigned          rop_w,
        input logic                 sign_ext
    );
        logic [EXT_MAX_W-1:0] low_mask;
        logic [EXT_MAX_W-1:0] low_bits;
        low_mask = (EXT_MAX_W'(1) << rop_w) - EXT_MAX_W'(1);
        low_bits = raw & low_mask;
        if (sign_ext && raw[rop_w-1]) begin
            return low_bits | ~low_mask;
        end
        return low_bits;
    endfunction

endpackage

// File: rtl/operand_ext.sv
// Immediate extender: widens the ROP_W-bit rop field to DATA_W (zero or sign fill).
module operand_ext
    import operand_mux_pkg::*;
#(
    parameter int unsigned ROP_W    = ROP_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter bit          SIGN_EXT = 1'b0
) (
    input  logic [ROP_W-1:0]  rop_i,
    output logic [DATA_W-1:0] ext_o
);

    always_comb begin
        ext_o = DATA_W'(ext_imm(EXT_MAX_W'(rop_i), ROP_W, SIGN_EXT));
    end

endmodule

// File: rtl/operand_mux.sv
// ALU second-operand selector: extended immediate (sel=0) or GPR (sel=1).
// Build option OPERAND_MUX_REG_EN registers data_out (1-cycle latency, reset to 0).
module operand_mux
    import operand_mux_pkg::*;
#(
    parameter int unsigned ROP_W    = ROP_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter bit          SIGN_EXT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic [ROP_W-1:0]  rop,
    input  logic [DATA_W-1:0] GPR,
    output logic [DATA_W-1:0] data_out,
    output logic              src_q
);

    if (!(DATA_W > ROP_W)) begin : g_bad_width
        $error("operand_mux: DATA_W must exceed ROP_W");
    end
    if (DATA_W > EXT_MAX_W) begin : g_bad_max
        $error("operand_mux: DATA_W exceeds extender limit");
    end

    logic [DATA_W-1:0] rop_ext;
    logic [DATA_W-1:0] mux_d;
    logic              src_d;

    operand_ext #(
        .ROP_W    (ROP_W),
        .DATA_W   (DATA_W),
        .SIGN_EXT (SIGN_EXT)
    ) u_ext (
        .rop_i (rop),
        .ext_o (rop_ext)
    );

    // Unknown select propagates as all-X rather than falling back to a source.
    always_comb begin
        mux_d = 'x;
        case (sel)
            SRC_ROP: mux_d = rop_ext;
            SRC_GPR: mux_d = GPR;
            default: mux_d = 'x;
        endcase
    end

    always_comb begin
        src_d = sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q <= 1'b0;
        end else begin
            src_q <= src_d;
        end
    end

`ifdef OPERAND_MUX_REG_EN
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= mux_d;
        end
    end

    always_comb begin
        data_out = data_q;
    end
`else
    always_comb begin
        data_out = mux_d;
    end
`endif

endmodule

// File: tb/tb_operand_mux.sv
// Self-checking bench for operand_mux: zero- and sign-extending instances, directed plus random steps.
module tb_operand_mux;

    logic        clk;
    logic        rst;
    logic        sel;
    logic [11:0] rop;
    logic [31:0] gpr;
    logic [31:0] dout_z;
    logic [31:0] dout_s;
    logic        srcq_z;
    logic        srcq_s;

    int unsigned passed;
    int unsigned total;

    operand_mux #(
        .ROP_W    (12),
        .DATA_W   (32),
        .SIGN_EXT (1'b0)
    ) dut_z (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .rop      (rop),
        .GPR      (gpr),
        .data_out (dout_z),
        .src_q    (srcq_z)
    );

    operand_mux #(
        .ROP_W    (12),
        .DATA_W   (32),
        .SIGN_EXT (1'b1)
    ) dut_s (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .rop      (rop),
        .GPR      (gpr),
        .data_out (dout_s),
        .src_q    (srcq_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand value as arithmetic on the 12-bit immediate: negative immediates gain 0xFFFFF000.
    function automatic logic [31:0] model(input logic s, input logic [11:0] r,
                                          input logic [31:0] g, input bit se);
        logic [31:0] v;
        if (s) return g;
        v = 32'(r);
        if (se && r >= 12'd2048) v = v + 32'hFFFF_F000;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Settles data_out for the current inputs: combinational build needs no edge.
    task automatic settle();
`ifdef OPERAND_MUX_REG_EN
        @(posedge clk);
`endif
        #1;
    endtask

    logic        exp_src;
    logic        r_rst;
    logic [31:0] prev_z;

    initial begin
        passed = 0;
        total  = 0;
        rst = 1'b1;
        sel = 1'b1;
        rop = 12'h000;
        gpr = 32'h0;

        // Reset held for two edges with sel=1: src_q must stay 0.
        @(posedge clk); #1;
        chk("rst_src_z_1", 32'(srcq_z), 32'd0);
        @(posedge clk); #1;
        chk("rst_src_z_2", 32'(srcq_z), 32'd0);
        chk("rst_src_s_2", 32'(srcq_s), 32'd0);
`ifdef OPERAND_MUX_REG_EN
        chk("rst_dout_z", dout_z, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("src_after_rel", 32'(srcq_z), 32'd1);

        // Directed boundaries on the zero-extending instance.
        @(negedge clk);
        sel = 1'b0; rop = 12'hFFF; gpr = 32'hFFFF_FFFF;
        settle();
        chk("rop_allones", dout_z, 32'h0000_0FFF);
        @(negedge clk);
        sel = 1'b1;
        settle();
        chk("gpr_allones", dout_z, 32'hFFFF_FFFF);
        @(negedge clk);
        sel = 1'b0;
        settle();
        chk("back_to_rop", dout_z, 32'h0000_0FFF);
        @(negedge clk);
        rop = 12'h000;
        settle();
        chk("rop_zero", dout_z, 32'h0);

        // Sign-extending instance around the sign boundary.
        @(negedge clk);
        sel = 1'b0; rop = 12'h800;
        settle();
        chk("sext_800", dout_s, 32'hFFFF_F800);
        chk("zext_800", dout_z, 32'h0000_0800);
        @(negedge clk);
        rop = 12'h7FF;
        settle();
        chk("sext_7ff", dout_s, 32'h0000_07FF);

`ifdef OPERAND_MUX_REG_EN
        // Registered build: output holds until the edge, then clears on reset.
        @(negedge clk);
        prev_z = dout_z;
        sel = 1'b1; gpr = 32'h1234_5678;
        #1;
        chk("reg_hold", dout_z, prev_z);
        @(posedge clk); #1;
        chk("reg_update", dout_z, 32'h1234_5678);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("reg_rst", dout_z, 32'd0);
        @(negedge clk);
        rst = 1'b0;
`else
        // Combinational build: reset does not touch data_out.
        @(negedge clk);
        sel = 1'b1; gpr = 32'h1234_5678; rst = 1'b1;
        #1;
        chk("comb_rst_dout", dout_z, 32'h1234_5678);
        @(posedge clk); #1;
        chk("comb_rst_src", 32'(srcq_z), 32'd0);
        @(negedge clk);
        rst = 1'b0;
`endif

        // Random steps: drive at negedge, check data path and src_q against the model.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            sel   = 1'($urandom);
            rop   = 12'($urandom);
            gpr   = $urandom;
            r_rst = ($urandom_range(0, 15) == 0);
            rst   = r_rst;
            exp_src = r_rst ? 1'b0 : sel;
`ifndef OPERAND_MUX_REG_EN
            #1;
            chk("rnd_dout_z", dout_z, model(sel, rop, gpr, 1'b0));
            chk("rnd_dout_s", dout_s, model(sel, rop, gpr, 1'b1));
`endif
            @(posedge clk); #1;
            chk("rnd_src_z", 32'(srcq_z), 32'(exp_src));
            chk("rnd_src_s", 32'(srcq_s), 32'(exp_src));
`ifdef OPERAND_MUX_REG_EN
            chk("rnd_dout_z", dout_z, r_rst ? 32'd0 : model(sel, rop, gpr, 1'b0));
            chk("rnd_dout_s", dout_s, r_rst ? 32'd0 : model(sel, rop, gpr, 1'b1));
`endif
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
